// File: rtl/machine_respond_pkg.sv
// Shared types and constants for the machine memory-command responder:
// bundle/slot geometry, tag values, FSM encoding and slot selection helpers.
package machine_types;

    localparam int R_SLOT_W    = 65;
    localparam int W_SLOT_W    = 95;
    localparam int CMD_W       = 320;
    localparam int RSP_W       = 130;
    localparam int TAG_W       = 2;
    localparam int SLOT_ADDR_W = 30;
    localparam int SLOT_DATA_W = 63;

    // Least significant bit of each slot inside the 320-bit command.
    localparam int R1_LSB = 255;
    localparam int R2_LSB = 190;
    localparam int W1_LSB = 95;
    localparam int W2_LSB = 0;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_JUST = 2'b01;

    // FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Slot identifiers in issue order; the pending mask is {r1, r2, w1, w2}.
    localparam logic [1:0] SLOT_R1 = 2'd0;
    localparam logic [1:0] SLOT_R2 = 2'd1;
    localparam logic [1:0] SLOT_W1 = 2'd2;
    localparam logic [1:0] SLOT_W2 = 2'd3;

    // Oldest-in-order pending slot (r1 first). Only meaningful when pend != 0.
    function automatic logic [1:0] first_slot(input logic [3:0] pend);
        if (pend[3])      return SLOT_R1;
        else if (pend[2]) return SLOT_R2;
        else if (pend[1]) return SLOT_W1;
        else              return SLOT_W2;
    endfunction

    // Pending-mask bit that belongs to a slot id.
    function automatic logic [3:0] slot_bit(input logic [1:0] s);
        return 4'b1000 >> s;
    endfunction

endpackage

// File: rtl/machine_slot_unpack.sv
// Splits one command slot into its fields. Read slots carry no value, so the
// value output is forced to zero for them and their padding is ignored.
module machine_slot_unpack
    import machine_types::*;
#(
    parameter int SLOT_W    = W_SLOT_W,
    parameter bit HAS_VALUE = 1'b1
)
(
    input  logic [SLOT_W-1:0]      slot,
    output logic                   valid,
    output logic                   err,
    output logic [SLOT_ADDR_W-1:0] addr,
    output logic [SLOT_DATA_W-1:0] value
);

    logic [TAG_W-1:0] tag;

    assign tag   = slot[SLOT_W-1 -: TAG_W];
    assign valid = (tag == TAG_JUST);
    // Tags 2'b10 and 2'b11 are malformed; the slot is skipped but flagged.
    assign err   = tag[1];
    assign addr  = slot[SLOT_W-TAG_W-1 -: SLOT_ADDR_W];

    generate
        if (HAS_VALUE) begin : g_value
            assign value = slot[SLOT_DATA_W-1:0];
        end else begin : g_no_value
            logic unused_pad;
            assign unused_pad = ^slot[SLOT_W-TAG_W-SLOT_ADDR_W-1:0];
            assign value      = '0;
        end
    endgenerate

endmodule

// File: rtl/machine_respond.sv
// Responder for the machine memory-command bundle. Accepts a bundle of up to
// two reads and two writes, issues the valid slots one per cycle in the order
// r1, r2, w1, w2 to a single-port synchronous RAM, and returns the read data.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid, once raised, holds its payload stable until that edge,
// and ready may be high before valid without side effects.
module machine_respond
    import machine_types::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 63
)
(
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RSP_W-1:0]  rsp,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    // Unpacked view of the incoming bundle, indexed by slot id.
    logic [3:0]        new_valid;
    logic [3:0]        new_err;
    logic [ADDR_W-1:0] new_addr [4];
    logic [DATA_W-1:0] new_val  [4];

    machine_slot_unpack #(.SLOT_W(R_SLOT_W), .HAS_VALUE(1'b0)) u_r1 (
        .slot (cmd[R1_LSB +: R_SLOT_W]),
        .valid(new_valid[3]),
        .err  (new_err[3]),
        .addr (new_addr[SLOT_R1]),
        .value(new_val[SLOT_R1])
    );

    machine_slot_unpack #(.SLOT_W(R_SLOT_W), .HAS_VALUE(1'b0)) u_r2 (
        .slot (cmd[R2_LSB +: R_SLOT_W]),
        .valid(new_valid[2]),
        .err  (new_err[2]),
        .addr (new_addr[SLOT_R2]),
        .value(new_val[SLOT_R2])
    );

    machine_slot_unpack #(.SLOT_W(W_SLOT_W), .HAS_VALUE(1'b1)) u_w1 (
        .slot (cmd[W1_LSB +: W_SLOT_W]),
        .valid(new_valid[1]),
        .err  (new_err[1]),
        .addr (new_addr[SLOT_W1]),
        .value(new_val[SLOT_W1])
    );

    machine_slot_unpack #(.SLOT_W(W_SLOT_W), .HAS_VALUE(1'b1)) u_w2 (
        .slot (cmd[W2_LSB +: W_SLOT_W]),
        .valid(new_valid[0]),
        .err  (new_err[0]),
        .addr (new_addr[SLOT_W2]),
        .value(new_val[SLOT_W2])
    );

    // Architectural state.
    logic [1:0]        state_q;
    logic [3:0]        pend_q;
    logic [ADDR_W-1:0] lat_addr_q [4];
    logic [DATA_W-1:0] lat_val_q  [4];
    logic              rd1_v_q;
    logic              rd2_v_q;
    logic [DATA_W-1:0] rd1_data_q;
    logic [DATA_W-1:0] rd2_data_q;
    logic              err_q;

    // Memory strobe registers and read-return tracking. mem_r2_q travels with
    // the strobe; rd_wait_q marks the cycle in which mem_rdata is valid.
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_r2_q;
    logic              rd_wait_q;
    logic              rd_wait_r2_q;

    // Next-slot selection. In IDLE the first slot is taken straight from the
    // incoming bundle so it can be strobed on the accept edge itself.
    logic [3:0]        src_mask;
    logic              pick_any;
    logic [1:0]        pick_slot;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic              pick_we;
    logic [3:0]        rest_mask;

    // Choose the oldest pending slot and its memory request.
    always_comb begin
        src_mask   = (state_q == ST_IDLE) ? new_valid : pend_q;
        pick_any   = |src_mask;
        pick_slot  = first_slot(src_mask);
        pick_we    = pick_slot[1];
        pick_addr  = (state_q == ST_IDLE) ? new_addr[pick_slot] : lat_addr_q[pick_slot];
        // Read slots hold a zero value, which gives mem_wdata = 0 on reads.
        pick_wdata = (state_q == ST_IDLE) ? new_val[pick_slot] : lat_val_q[pick_slot];
        rest_mask  = src_mask & ~slot_bit(pick_slot);
    end

    // Bundle FSM, memory strobes and read-data capture.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                lat_addr_q[i] <= '0;
                lat_val_q[i]  <= '0;
            end
            rd1_v_q      <= 1'b0;
            rd2_v_q      <= 1'b0;
            rd1_data_q   <= '0;
            rd2_data_q   <= '0;
            err_q        <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_r2_q     <= 1'b0;
            rd_wait_q    <= 1'b0;
            rd_wait_r2_q <= 1'b0;
        end else begin
            // A read strobed last cycle is sampled by the RAM on this edge,
            // so its data is presented during the next cycle and taken then.
            rd_wait_q    <= mem_en_q && !mem_we_q;
            rd_wait_r2_q <= mem_r2_q;
            if (rd_wait_q) begin
                if (rd_wait_r2_q) rd2_data_q <= mem_rdata;
                else              rd1_data_q <= mem_rdata;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            lat_addr_q[i] <= new_addr[i];
                            lat_val_q[i]  <= new_val[i];
                        end
                        rd1_v_q    <= new_valid[3];
                        rd2_v_q    <= new_valid[2];
                        rd1_data_q <= '0;
                        rd2_data_q <= '0;
                        err_q      <= |new_err;
                        if (pick_any) begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= pick_we;
                            mem_addr_q  <= pick_addr;
                            mem_wdata_q <= pick_wdata;
                            mem_r2_q    <= (pick_slot == SLOT_R2);
                            pend_q      <= rest_mask;
                            state_q     <= ST_ISSUE;
                        end else begin
                            pend_q  <= '0;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (pick_any) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= pick_we;
                        mem_addr_q  <= pick_addr;
                        mem_wdata_q <= pick_wdata;
                        mem_r2_q    <= (pick_slot == SLOT_R2);
                        pend_q      <= rest_mask;
                    end else begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        mem_r2_q <= 1'b0;
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_RESP;
                end
                default: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp       = {rd1_v_q ? TAG_JUST : TAG_NONE, rd1_data_q,
                        rd2_v_q ? TAG_JUST : TAG_NONE, rd2_data_q};

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_machine_respond.sv
// Bench for machine_respond: directed scenarios followed by random bundles.
// Expected responses and memory accesses come from a slot-level model of the
// bundle rules and are queued at issue time; monitors compare on DUT activity.
module tb_machine_respond;
    import machine_types::*;

    localparam int AW    = 30;
    localparam int DW    = 63;
    localparam int EXP_W = 8 + 1 + 130;
    localparam int ACC_W = 8 + 1 + 30 + 63;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [319:0]   cmd = '0;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [129:0]   rsp;
    logic           rsp_err;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;
    logic [1:0]     dbg_state;

    machine_respond #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .system1000     (clk),
        .system1000_rstn(rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd            (cmd),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp            (rsp),
        .rsp_err        (rsp_err),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench memory (read-first synchronous RAM) ----------------
    logic [DW-1:0] tb_ram  [0:31];
    logic [DW-1:0] ref_ram [0:31];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_ram[mem_addr[4:0]] <= mem_wdata;
            else        mem_rdata <= tb_ram[mem_addr[4:0]];
        end
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EXP_W-1:0] exp_q [$];
    logic [ACC_W-1:0] acc_q [$];
    int   acc_cyc = 0;
    bit   mon_en = 1'b0;
    bit   prev_valid = 1'b0;
    bit   ready_next = 1'b0;
    logic [129:0] held_rsp;
    logic         held_err;
    int   rr_mode = 0;
    int   hold_cnt = 0;

    // Current bundle, slot order r1, r2, w1, w2.
    logic [1:0]    b_tag  [4];
    logic [AW-1:0] b_addr [4];
    logic [DW-1:0] b_val  [4];

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [319:0] build_cmd();
        return {b_tag[0], b_addr[0], 33'b0,
                b_tag[1], b_addr[1], 33'b0,
                b_tag[2], b_addr[2], b_val[2],
                b_tag[3], b_addr[3], b_val[3]};
    endfunction

    // Reference: reads see memory before this bundle's writes; valid slots
    // occupy consecutive cycles from 1; response arrives two cycles after the
    // last access, or in cycle 1 when nothing is valid.
    task automatic model_bundle();
        int k = 0;
        int lat;
        logic [64:0] rd [2];
        logic err = 1'b0;
        for (int i = 0; i < 4; i++) if (b_tag[i][1]) err = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = '0;
            if (b_tag[i] == 2'b01) begin
                rd[i] = {2'b01, ref_ram[b_addr[i][4:0]]};
                acc_q.push_back({8'(k + 1), 1'b0, b_addr[i], 63'b0});
                k++;
            end
        end
        for (int i = 2; i < 4; i++) begin
            if (b_tag[i] == 2'b01) begin
                acc_q.push_back({8'(k + 1), 1'b1, b_addr[i], b_val[i]});
                ref_ram[b_addr[i][4:0]] = b_val[i];
                k++;
            end
        end
        lat = (k == 0) ? 1 : k + 2;
        exp_q.push_back({8'(lat), err, rd[0], rd[1]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bundle(input bit use_model);
        int guard = 0;
        @(posedge clk); #1;
        while (!cmd_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_ready_timeout");
            return;
        end
        cmd = build_cmd();
        cmd_valid = 1'b1;
        if (use_model) model_bundle();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || acc_q.size() != 0 || !cmd_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) fail_now("wait_idle_timeout");
    endtask

    task automatic set_slot(input int i, input logic [1:0] t, input int a, input logic [DW-1:0] v);
        b_tag[i]  = t;
        b_addr[i] = AW'(a);
        b_val[i]  = (i < 2) ? '0 : v;
    endtask

    task automatic random_bundle();
        for (int i = 0; i < 4; i++) begin
            int r;
            r = $urandom_range(0, 9);
            set_slot(i, (r < 4) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11,
                     $urandom_range(0, 7), {$urandom, $urandom});
        end
    endtask

    // ---------------- rsp_ready driver ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (rsp_valid && hold_cnt < 5) begin
                        rsp_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        rsp_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (mon_en && rst_n) begin
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    fail_now("unexpected_mem_access");
                end else begin
                    logic [ACC_W-1:0] e;
                    e = acc_q.pop_front();
                    check("mem_access", {8'(cyc - acc_cyc), mem_we, mem_addr, mem_wdata}, e);
                end
            end
            if (rsp_valid) begin
                check("cmd_ready_in_resp", cmd_ready, 1'b0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) fail_now("unexpected_rsp");
                    else check("rsp_latency", 8'(cyc - acc_cyc), exp_q[0][138:131]);
                    held_rsp = rsp;
                    held_err = rsp_err;
                end else begin
                    check("rsp_stable", {rsp_err, rsp}, {held_err, held_rsp});
                end
                if (rsp_ready) begin
                    if (exp_q.size() != 0) begin
                        logic [EXP_W-1:0] e;
                        e = exp_q.pop_front();
                        check("rsp_data", rsp, e[129:0]);
                        check("rsp_err", rsp_err, e[130]);
                    end
                    check("accesses_complete", acc_q.size(), 0);
                    ready_next = 1'b1;
                end
            end else if (ready_next) begin
                check("cmd_ready_after_rsp", cmd_ready, 1'b1);
                ready_next = 1'b0;
            end
            prev_valid = rsp_valid;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        fail_now("watchdog_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            tb_ram[i]  = {$urandom, $urandom};
            ref_ram[i] = tb_ram[i];
        end
        tb_ram[5] = 63'h11; ref_ram[5] = 63'h11;
        tb_ram[9] = 63'h22; ref_ram[9] = 63'h22;
        tb_ram[3] = 63'h5A; ref_ram[3] = 63'h5A;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_rsp", rsp, 130'b0);
        check("reset_mem_addr", mem_addr, 30'b0);
        check("reset_mem_wdata", mem_wdata, 63'b0);

        // Reset while the second read of a four-slot bundle is on the bus.
        set_slot(0, 2'b01, 1, 0);
        set_slot(1, 2'b01, 2, 0);
        set_slot(2, 2'b01, 1, 63'h55);
        set_slot(3, 2'b01, 2, 63'h66);
        send_bundle(1'b0);
        @(posedge clk); #2;
        check("mid_bundle_mem_en_before", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_bundle_mem_en_drop", mem_en, 1'b0);
        check("mid_bundle_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1'b1);
        check("post_reset_rsp_valid", rsp_valid, 1'b0);
        check("post_reset_mem_en", mem_en, 1'b0);
        check("post_reset_ram1", tb_ram[1], ref_ram[1]);
        check("post_reset_ram2", tb_ram[2], ref_ram[2]);
        mon_en = 1'b1;
        rr_mode = 0;

        // Full bundle, w1 hits the address r1 reads.
        set_slot(0, 2'b01, 5, 0);
        set_slot(1, 2'b01, 9, 0);
        set_slot(2, 2'b01, 5, 63'h77);
        set_slot(3, 2'b01, 12, 63'h33);
        send_bundle(1'b1);
        wait_idle();
        check("full_ram5", tb_ram[5], 63'h77);
        check("full_ram12", tb_ram[12], 63'h33);

        // Empty bundle.
        set_slot(0, 2'b00, 4, 0);
        set_slot(1, 2'b00, 6, 0);
        set_slot(2, 2'b00, 8, 63'h1);
        set_slot(3, 2'b00, 10, 63'h2);
        send_bundle(1'b1);
        wait_idle();

        // r2 only plus w1 to the same word.
        set_slot(0, 2'b00, 0, 0);
        set_slot(1, 2'b01, 3, 0);
        set_slot(2, 2'b01, 3, 63'h01);
        set_slot(3, 2'b00, 0, 0);
        send_bundle(1'b1);
        wait_idle();
        check("r2w1_ram3", tb_ram[3], 63'h01);

        // Malformed r1 tag; only w2 executes.
        set_slot(0, 2'b10, 7, 0);
        set_slot(1, 2'b00, 0, 0);
        set_slot(2, 2'b00, 0, 0);
        set_slot(3, 2'b01, 4, 63'h9);
        send_bundle(1'b1);
        wait_idle();
        check("badtag_ram4", tb_ram[4], 63'h9);

        // Back-pressure: consumer stalls five cycles in RESP.
        hold_cnt = 0;
        rr_mode = 2;
        set_slot(0, 2'b01, 1, 0);
        set_slot(1, 2'b11, 2, 0);
        set_slot(2, 2'b01, 6, 63'h1234);
        set_slot(3, 2'b00, 0, 0);
        send_bundle(1'b1);
        wait_idle();

        // Random bundles with random consumer stalls.
        rr_mode = 1;
        for (int n = 0; n < 60; n++) begin
            random_bundle();
            send_bundle(1'b1);
        end
        wait_idle();
        for (int i = 0; i < 32; i++) check("final_ram", tb_ram[i], ref_ram[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
